// File: rtl/vend_pkg.sv
// Shared codes, state encoding and price lookup for the vending transaction controller.
package vend_pkg;

    localparam int unsigned COIN_5_RS  = 5;
    localparam int unsigned COIN_10_RS = 10;

    typedef enum logic {
        COIN_5  = 1'b0,
        COIN_10 = 1'b1
    } coin_t;

    typedef enum logic [1:0] {
        PROD_A = 2'd0,
        PROD_B = 2'd1,
        PROD_C = 2'd2,
        PROD_D = 2'd3
    } product_t;

    // Busy states share bit 1 so DISPENSE/PAYOUT are easy to spot in waveforms.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_COLLECT  = 2'd1,
        ST_DISPENSE = 2'd2,
        ST_PAYOUT   = 2'd3
    } state_t;

    // Map a product code to its price in Rs.
    function automatic int unsigned price_of(input logic [1:0] product,
                                             input int unsigned price_a,
                                             input int unsigned price_b,
                                             input int unsigned price_c,
                                             input int unsigned price_d);
        case (product)
            PROD_A:  return price_a;
            PROD_B:  return price_b;
            PROD_C:  return price_c;
            default: return price_d;
        endcase
    endfunction

endpackage

// File: rtl/vend_timer.sv
// Loadable down-counter: load starts a LIMIT-cycle window, clear stops it,
// expire_c is high for exactly the last cycle of an uninterrupted window.
module vend_timer #(
    parameter int unsigned LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic clear,
    output logic expire_c
);
    localparam int unsigned CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

    logic [CNT_W-1:0] cnt;
    logic             active;

    // Count down while active; load wins over clear so a restart is never lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            active <= 1'b0;
        end else if (load) begin
            cnt    <= CNT_W'(LIMIT - 1);
            active <= 1'b1;
        end else if (clear) begin
            active <= 1'b0;
        end else if (active) begin
            if (cnt == '0) begin
                active <= 1'b0;
            end else begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    assign expire_c = active && (cnt == '0);

endmodule

// File: rtl/vend_txn_controller.sv
// Vending transaction sequencer: credit accumulation, selection check,
// dispenser handshake and 5 Rs change payout.
module vend_txn_controller
    import vend_pkg::*;
#(
    parameter int unsigned CREDIT_W     = 6,
    parameter int unsigned MAX_CREDIT   = 40,
    parameter int unsigned PRICE_A      = 5,
    parameter int unsigned PRICE_B      = 10,
    parameter int unsigned PRICE_C      = 15,
    parameter int unsigned PRICE_D      = 20,
    parameter int unsigned IDLE_TIMEOUT = 1000,
    parameter int unsigned DISP_TIMEOUT = 500
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_coin_valid,
    input  logic                in_coin_type,
    input  logic                in_sel_valid,
    input  logic [1:0]          in_product,
    input  logic                in_cancel,
    output logic                out_dispense_req,
    input  logic                in_dispense_ack,
    output logic                out_change_req,
    input  logic                in_change_ack,
    output logic [CREDIT_W-1:0] out_credit,
    output logic                out_coin_reject,
    output logic                out_short,
    output logic                out_vend_done,
    output logic                out_error,
    output logic                out_busy
);
    localparam int unsigned SUM_W = CREDIT_W + 1;

    state_t              state;
    logic [CREDIT_W-1:0] price_q;
    logic [CREDIT_W-1:0] sel_price;
    logic [SUM_W-1:0]    coin_sum;
    logic                coin_fits;
    logic                activity;
    logic                in_collect;
    logic                quiet_expire;
    logic                idle_expire_c;
    logic                disp_expire_c;

    assign in_collect   = (state == ST_COLLECT);
    assign activity     = in_coin_valid | in_sel_valid | in_cancel;
    assign coin_sum     = {1'b0, out_credit} + ((in_coin_type == COIN_10) ? SUM_W'(COIN_10_RS)
                                                                          : SUM_W'(COIN_5_RS));
    assign coin_fits    = (coin_sum <= SUM_W'(MAX_CREDIT));
    assign sel_price    = CREDIT_W'(price_of(in_product, PRICE_A, PRICE_B, PRICE_C, PRICE_D));
    // A coin/select/cancel in the expiry cycle counts as activity and suppresses the refund.
    assign quiet_expire = in_collect & idle_expire_c & ~activity;

    vend_timer #(.LIMIT(IDLE_TIMEOUT)) u_idle_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (((state == ST_IDLE) || in_collect) && activity),
        .clear    (!in_collect),
        .expire_c (idle_expire_c)
    );

    vend_timer #(.LIMIT(DISP_TIMEOUT)) u_disp_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (in_collect && in_sel_valid),
        .clear    (state != ST_DISPENSE),
        .expire_c (disp_expire_c)
    );

    // Transaction FSM with registered credit, handshakes and status pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= ST_IDLE;
            out_credit       <= '0;
            price_q          <= '0;
            out_dispense_req <= 1'b0;
            out_change_req   <= 1'b0;
            out_coin_reject  <= 1'b0;
            out_short        <= 1'b0;
            out_vend_done    <= 1'b0;
            out_error        <= 1'b0;
            out_busy         <= 1'b0;
        end else begin
            out_coin_reject <= 1'b0;
            out_short       <= 1'b0;
            out_vend_done   <= 1'b0;
            out_error       <= 1'b0;

            case (state)
                ST_IDLE, ST_COLLECT: begin
                    if (in_coin_valid) begin
                        if (coin_fits) begin
                            out_credit <= coin_sum[CREDIT_W-1:0];
                            state      <= ST_COLLECT;
                        end else begin
                            out_coin_reject <= 1'b1;
                        end
                    end
                    // Cancel beats select; select sees the pre-coin credit.
                    if (in_collect && (in_cancel || quiet_expire)) begin
                        state          <= ST_PAYOUT;
                        out_change_req <= 1'b1;
                        out_busy       <= 1'b1;
                    end else if (in_sel_valid) begin
                        if (in_collect && (sel_price <= out_credit)) begin
                            state            <= ST_DISPENSE;
                            price_q          <= sel_price;
                            out_dispense_req <= 1'b1;
                            out_busy         <= 1'b1;
                        end else begin
                            out_short <= 1'b1;
                        end
                    end
                end

                ST_DISPENSE: begin
                    out_coin_reject <= in_coin_valid;
                    if (in_dispense_ack) begin
                        out_dispense_req <= 1'b0;
                        out_vend_done    <= 1'b1;
                        out_credit       <= out_credit - price_q;
                        if (out_credit != price_q) begin
                            state          <= ST_PAYOUT;
                            out_change_req <= 1'b1;
                        end else begin
                            state    <= ST_IDLE;
                            out_busy <= 1'b0;
                        end
                    end else if (disp_expire_c) begin
                        out_dispense_req <= 1'b0;
                        out_error        <= 1'b1;
                        out_change_req   <= 1'b1;
                        state            <= ST_PAYOUT;
                    end
                end

                ST_PAYOUT: begin
                    out_coin_reject <= in_coin_valid;
                    // Return-to-zero: drop after each ack, re-raise one idle cycle later.
                    if (out_change_req && in_change_ack && (out_credit >= CREDIT_W'(COIN_5_RS))) begin
                        out_credit     <= out_credit - CREDIT_W'(COIN_5_RS);
                        out_change_req <= 1'b0;
                        if (out_credit == CREDIT_W'(COIN_5_RS)) begin
                            state    <= ST_IDLE;
                            out_busy <= 1'b0;
                        end
                    end else if (!out_change_req && (out_credit != '0)) begin
                        out_change_req <= 1'b1;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vend_txn_controller.sv
// Bench for vend_txn_controller: cycle model compared every clock plus directed literal checks.
module tb_vend_txn_controller;
    localparam int CREDIT_W   = 6;
    localparam int MAX_CREDIT = 40;
    localparam int IDLE_TO    = 1000;
    localparam int DISP_TO    = 500;

    localparam int PH_IDLE = 0, PH_COLLECT = 1, PH_DISPENSE = 2, PH_PAYOUT = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_coin_valid = 1'b0, in_coin_type = 1'b0, in_sel_valid = 1'b0, in_cancel = 1'b0;
    logic [1:0] in_product = 2'd0;
    logic in_dispense_ack = 1'b0, in_change_ack = 1'b0;
    logic out_dispense_req, out_change_req, out_coin_reject, out_short;
    logic out_vend_done, out_error, out_busy;
    logic [CREDIT_W-1:0] out_credit;

    int n_pass = 0, n_total = 0;
    int cnt_done = 0, cnt_err = 0;
    int price_tbl[4] = '{5, 10, 15, 20};

    // Model state: what the controller must be showing after the latest clock.
    int m_credit = 0, m_phase = PH_IDLE, m_price = 0, m_quiet = 0, m_wait = 0, m_since = 2;
    bit e_rej = 0, e_short = 0, e_done = 0, e_err = 0;

    vend_txn_controller #(
        .CREDIT_W(CREDIT_W), .MAX_CREDIT(MAX_CREDIT),
        .IDLE_TIMEOUT(IDLE_TO), .DISP_TIMEOUT(DISP_TO)
    ) dut (
        .clk(clk), .rst(rst),
        .in_coin_valid(in_coin_valid), .in_coin_type(in_coin_type),
        .in_sel_valid(in_sel_valid), .in_product(in_product), .in_cancel(in_cancel),
        .out_dispense_req(out_dispense_req), .in_dispense_ack(in_dispense_ack),
        .out_change_req(out_change_req), .in_change_ack(in_change_ack),
        .out_credit(out_credit), .out_coin_reject(out_coin_reject), .out_short(out_short),
        .out_vend_done(out_vend_done), .out_error(out_error), .out_busy(out_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    endtask

    function automatic bit exp_chg();
        return (m_phase == PH_PAYOUT) && (m_credit > 0) && (m_since >= 2);
    endfunction

    // Advance the model on each clock from the sampled inputs, then compare every output.
    always @(posedge clk) begin
        bit act, req_pre, was_collect;
        int cv, pre;
        if (rst) begin
            m_credit = 0; m_phase = PH_IDLE; m_price = 0; m_quiet = 0; m_wait = 0; m_since = 2;
            e_rej = 0; e_short = 0; e_done = 0; e_err = 0;
        end else begin
            e_rej = 0; e_short = 0; e_done = 0; e_err = 0;
            act = in_coin_valid | in_sel_valid | in_cancel;
            cv = in_coin_type ? 10 : 5;
            req_pre = exp_chg();
            pre = m_credit;
            was_collect = (m_phase == PH_COLLECT);
            if (m_phase == PH_IDLE || m_phase == PH_COLLECT) begin
                if (in_coin_valid) begin
                    if (pre + cv <= MAX_CREDIT) begin m_credit = pre + cv; m_phase = PH_COLLECT; end
                    else e_rej = 1;
                end
                if (was_collect && (in_cancel || (!act && m_quiet + 1 >= IDLE_TO))) begin
                    m_phase = PH_PAYOUT; m_since = 2;
                end else if (in_sel_valid) begin
                    if (was_collect && price_tbl[in_product] <= pre) begin
                        m_phase = PH_DISPENSE; m_price = price_tbl[in_product]; m_wait = 0;
                    end else e_short = 1;
                end
                m_quiet = act ? 0 : m_quiet + 1;
            end else if (m_phase == PH_DISPENSE) begin
                e_rej = in_coin_valid;
                if (in_dispense_ack) begin
                    e_done = 1; m_credit = m_credit - m_price; m_since = 2;
                    m_phase = (m_credit > 0) ? PH_PAYOUT : PH_IDLE;
                end else begin
                    m_wait++;
                    if (m_wait >= DISP_TO) begin e_err = 1; m_phase = PH_PAYOUT; m_since = 2; end
                end
            end else begin
                e_rej = in_coin_valid;
                if (req_pre && in_change_ack) begin
                    m_credit = m_credit - 5; m_since = 1;
                    if (m_credit == 0) m_phase = PH_IDLE;
                end else if (m_since < 2) m_since++;
            end
        end
        #1;
        chk("credit", 32'(out_credit), 32'(m_credit));
        chk("dispense_req", 32'(out_dispense_req), 32'(m_phase == PH_DISPENSE));
        chk("change_req", 32'(out_change_req), 32'(exp_chg()));
        chk("busy", 32'(out_busy), 32'(m_phase == PH_DISPENSE || m_phase == PH_PAYOUT));
        chk("coin_reject", 32'(out_coin_reject), 32'(e_rej));
        chk("short", 32'(out_short), 32'(e_short));
        chk("vend_done", 32'(out_vend_done), 32'(e_done));
        chk("error", 32'(out_error), 32'(e_err));
        if (out_vend_done) cnt_done++;
        if (out_error) cnt_err++;
    end

    task automatic drive(input bit cv, input bit ct, input bit sv, input logic [1:0] pr, input bit cc);
        in_coin_valid = cv; in_coin_type = ct; in_sel_valid = sv; in_product = pr; in_cancel = cc;
        @(negedge clk);
        in_coin_valid = 0; in_sel_valid = 0; in_cancel = 0;
    endtask

    task automatic coin(input bit ten);          drive(1, ten, 0, 2'd0, 0); endtask
    task automatic sel(input logic [1:0] p);     drive(0, 0, 1, p, 0);      endtask
    task automatic cancel();                     drive(0, 0, 0, 2'd0, 1);   endtask
    task automatic idle(input int n);            repeat (n) @(negedge clk); endtask

    task automatic dack();
        in_dispense_ack = 1;
        @(negedge clk);
        in_dispense_ack = 0;
    endtask

    // Acknowledge every change request until the controller leaves PAYOUT.
    task automatic serve_payout(output int n);
        n = 0;
        for (int i = 0; i < 400; i++) begin
            if (in_change_ack) in_change_ack = 0;
            else if (out_change_req) begin in_change_ack = 1; n++; end
            else if (!out_busy) return;
            @(negedge clk);
        end
        in_change_ack = 0;
        n_total++;
        $display("FAIL payout_budget: still busy after 400 cycles, credit %0d", out_credit);
    endtask

    initial begin
        int n, d0, e0;
        repeat (2) @(negedge clk);
        chk("rst_credit", 32'(out_credit), 0);
        chk("rst_busy", 32'(out_busy), 0);
        rst = 0;
        idle(1);

        // 10 Rs, select B, ack three cycles after the select
        coin(1);              chk("s1_credit10", 32'(out_credit), 10);
        sel(2'd1);            chk("s1_dreq", 32'(out_dispense_req), 1);
        idle(2); dack();
        chk("s1_done", 32'(out_vend_done), 1);
        chk("s1_credit0", 32'(out_credit), 0);
        chk("s1_no_chg", 32'(out_change_req), 0);
        chk("s1_idle", 32'(out_busy), 0);

        // 10+10, select C, one coin of change
        coin(1); coin(1);     chk("s2_credit20", 32'(out_credit), 20);
        sel(2'd2); idle(1); dack();
        chk("s2_credit5", 32'(out_credit), 5);
        serve_payout(n);      chk("s2_coins", 32'(n), 1);
        chk("s2_credit0", 32'(out_credit), 0);

        // 5 Rs, select D is short, then cancel refunds
        coin(0); sel(2'd3);   chk("s3_short", 32'(out_short), 1);
        chk("s3_credit5", 32'(out_credit), 5);
        cancel(); serve_payout(n); chk("s3_coins", 32'(n), 1);

        // Credit ceiling and coin during DISPENSE
        repeat (4) coin(1);   chk("s4_credit40", 32'(out_credit), 40);
        coin(0);              chk("s4_reject", 32'(out_coin_reject), 1);
        chk("s4_credit_hold", 32'(out_credit), 40);
        sel(2'd0); coin(1);   chk("s4_disp_reject", 32'(out_coin_reject), 1);
        chk("s4_credit_disp", 32'(out_credit), 40);
        dack();               chk("s4_credit35", 32'(out_credit), 35);
        serve_payout(n);      chk("s4_coins", 32'(n), 7);

        // Dispense timeout: error, full refund, no vend
        d0 = cnt_done; e0 = cnt_err;
        coin(1); coin(1); sel(2'd0);
        idle(DISP_TO - 1);    chk("s5_pre_err", 32'(out_error), 0);
        chk("s5_still_req", 32'(out_dispense_req), 1);
        idle(1);              chk("s5_err", 32'(out_error), 1);
        chk("s5_credit20", 32'(out_credit), 20);
        serve_payout(n);      chk("s5_coins", 32'(n), 4);
        chk("s5_no_vend", 32'(cnt_done - d0), 0);
        chk("s5_one_err", 32'(cnt_err - e0), 1);

        // Inactivity refund of 15 Rs
        coin(1); coin(0);
        idle(IDLE_TO - 1);    chk("s6_pre_to", 32'(out_busy), 0);
        idle(1);              chk("s6_to_busy", 32'(out_busy), 1);
        chk("s6_credit15", 32'(out_credit), 15);
        serve_payout(n);      chk("s6_coins", 32'(n), 3);

        // Select in IDLE, stray dispense ack, coin+select, cancel+select
        sel(2'd0);            chk("s8_idle_short", 32'(out_short), 1);
        dack();               chk("s8_stray_ack", 32'(out_vend_done), 0);
        coin(0);
        drive(1, 1, 1, 2'd1, 0); chk("s8_precoin_short", 32'(out_short), 1);
        chk("s8_credit15", 32'(out_credit), 15);
        drive(1, 0, 1, 2'd2, 0); chk("s8_dreq", 32'(out_dispense_req), 1);
        chk("s8_credit20", 32'(out_credit), 20);
        dack(); serve_payout(n); chk("s8_coins", 32'(n), 1);
        coin(1);
        drive(0, 0, 1, 2'd0, 1); chk("s8_cancel_wins", 32'(out_dispense_req), 0);
        chk("s8_cancel_chg", 32'(out_change_req), 1);
        serve_payout(n);      chk("s8_cancel_coins", 32'(n), 2);

        // Asynchronous reset in the middle of PAYOUT
        coin(1); coin(1); cancel();
        chk("s7_chg", 32'(out_change_req), 1);
        #2 rst = 1;
        #1;
        chk("s7_rst_chg", 32'(out_change_req), 0);
        chk("s7_rst_credit", 32'(out_credit), 0);
        chk("s7_rst_busy", 32'(out_busy), 0);
        @(negedge clk); rst = 0;
        idle(2);
        coin(0); cancel(); serve_payout(n); chk("s7_after_coins", 32'(n), 1);
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
